// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
//   Instruction fetch unit: owns the fetch PC, issues one ICache request at a time over an
//   addr_ok/data_ok handshake, predecodes the returned word (jal and backward branches are
//   predicted taken) and pushes {inst, pc, pred} into a circular fetch queue read by decode.
//   A back-end redirect flushes the queue, reloads the PC and discards any in-flight fetch.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   redirect, redirect_pc    back-end flush and its new fetch PC
//   ic_req, ic_addr          fetch request valid / address
//   ic_addr_ok, ic_data_ok   ICache request accept / data return strobes
//   ic_rdata                 returned instruction
//   id_valid, id_ready       queue head valid / decode consumes head
//   id_inst, id_pc           head instruction and its PC
//   id_pred_taken            head was predicted taken
//   fq_count                 queue occupancy
module ifu_fetch_queue #(
   parameter int unsigned PC_W     = 64,
   parameter int unsigned INST_W   = 32,
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned FQ_DEPTH = 4,
   parameter int unsigned CNT_W    = $clog2(FQ_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              ic_req,
   output logic [PC_W-1:0]   ic_addr,
   input  logic              ic_addr_ok,
   input  logic              ic_data_ok,
   input  logic [INST_W-1:0] ic_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc,
   output logic              id_pred_taken,
   output logic [CNT_W-1:0]  fq_count
);

   localparam int unsigned      PTR_W    = $clog2(FQ_DEPTH);
   localparam logic [PC_W-1:0]  RST_PC   = PC_W'(RESET_PC);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

   // StDrop: a request is still in flight but its data belongs to a flushed path.
   typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]   req_pc_q, req_pc_d;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [INST_W-1:0] fq_inst_q [FQ_DEPTH];
   logic [PC_W-1:0]   fq_pc_q [FQ_DEPTH];
   logic [FQ_DEPTH-1:0] fq_pred_q;

   logic accept, enq, deq;

   // Predecode of the returned word (RV32 encodings)
   logic [6:0]      opcode;
   logic            is_jal, is_bwd_br, pred_taken;
   logic [20:0]     jal_imm;
   logic [12:0]     br_imm;
   logic [PC_W-1:0] jal_off, br_off, pred_target;

   assign opcode      = ic_rdata[6:0];
   assign is_jal      = (opcode == 7'b1101111);
   assign is_bwd_br   = (opcode == 7'b1100011) && ic_rdata[31];
   assign pred_taken  = is_jal | is_bwd_br;
   assign jal_imm     = {ic_rdata[31], ic_rdata[19:12], ic_rdata[20], ic_rdata[30:21], 1'b0};
   assign br_imm      = {ic_rdata[31], ic_rdata[7], ic_rdata[30:25], ic_rdata[11:8], 1'b0};
   assign jal_off     = {{(PC_W-21){jal_imm[20]}}, jal_imm};
   assign br_off      = {{(PC_W-13){br_imm[12]}}, br_imm};
   assign pred_target = req_pc_q + (is_jal ? jal_off : br_off);

   // A request is only issued with a free slot, so the later enqueue cannot overflow.
   assign ic_req  = ~rst & (state_q == StReq) & (count_q < FULL_CNT) & ~redirect;
   assign ic_addr = fetch_pc_q;
   assign accept  = ic_req & ic_addr_ok;
   assign enq     = (state_q == StWait) & ic_data_ok & ~redirect;
   assign deq     = id_valid & id_ready & ~redirect;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         unique case (state_q)
            StReq:   if (ic_addr_ok) state_d = StDrop;
            StWait:  state_d = ic_data_ok ? StReq : StDrop;
            StDrop:  if (ic_data_ok) state_d = StReq;
            default: state_d = StReq;
         endcase
      end else begin
         unique case (state_q)
            StReq: begin
               if (accept) begin
                  state_d  = StWait;
                  req_pc_d = fetch_pc_q;
               end
            end
            StWait: begin
               if (ic_data_ok) begin
                  state_d    = StReq;
                  fetch_pc_d = pred_taken ? pred_target : req_pc_q + PC_W'(4);
               end
            end
            StDrop:  if (ic_data_ok) state_d = StReq;
            default: state_d = StReq;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StReq;
         fetch_pc_q <= RST_PC;
         req_pc_q   <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         if (redirect) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (deq) head_q <= head_q + PTR_W'(1);
            case ({enq, deq})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Payload storage needs no reset: outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (enq) begin
         fq_inst_q[tail_q] <= ic_rdata;
         fq_pc_q[tail_q]   <= req_pc_q;
         fq_pred_q[tail_q] <= pred_taken;
      end
   end

   assign id_valid      = (count_q != '0);
   assign id_inst       = id_valid ? fq_inst_q[head_q] : '0;
   assign id_pc         = id_valid ? fq_pc_q[head_q] : '0;
   assign id_pred_taken = id_valid & fq_pred_q[head_q];
   assign fq_count      = count_q;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
   localparam int unsigned PC_W = 64, INST_W = 32, FQ_DEPTH = 4, CNT_W = 3;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst, redirect, ic_req, ic_addr_ok, ic_data_ok, id_valid, id_ready, id_pred_taken;
   logic [PC_W-1:0] redirect_pc, ic_addr, id_pc;
   logic [INST_W-1:0] ic_rdata, id_inst;
   logic [CNT_W-1:0] fq_count;

   always #5 clk = ~clk;

   ifu_fetch_queue #(
      .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_addr_ok(ic_addr_ok), .ic_data_ok(ic_data_ok),
      .ic_rdata(ic_rdata), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
      .id_pc(id_pc), .id_pred_taken(id_pred_taken), .fq_count(fq_count)
   );

   // Reference model: fetch PC, one outstanding-request flag, a stale flag and a queue.
   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        pred;
   } entry_t;
   typedef logic [165:0] vec_t;

   entry_t      mq[$];
   logic [63:0] m_pc, m_req_pc;
   bit          m_pending, m_stale;
   int          tests = 0;
   int          fails = 0;

   function automatic void m_reset();
      mq.delete();
      m_pc = RST_PC;
      m_req_pc = '0;
      m_pending = 0;
      m_stale = 0;
   endfunction

   function automatic bit pred_of(input logic [31:0] i);
      return (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100011 && i[31]);
   endfunction

   function automatic logic [63:0] target_of(input logic [31:0] i, input logic [63:0] pc);
      longint off;
      if (i[6:0] == 7'b1101111)
         off = (i[31] ? -longint'(1 << 20) : 0) + longint'(i[19:12]) * 4096
               + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      else
         off = (i[31] ? -longint'(4096) : 0) + longint'(i[7]) * 2048
               + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      return pc + off;
   endfunction

   function automatic bit exp_req();
      return !rst && !m_pending && !m_stale && mq.size() < FQ_DEPTH && !redirect;
   endfunction

   function automatic vec_t exp_vec();
      entry_t h = '0;
      if (mq.size() != 0) h = mq[0];
      return {exp_req(), m_pc, mq.size() != 0, h.inst, h.pc, h.pred, 3'(mq.size())};
   endfunction

   function automatic vec_t obs_vec();
      return {ic_req, ic_addr, id_valid, id_inst, id_pc, id_pred_taken, fq_count};
   endfunction

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_step();
      entry_t e;
      bit deq = (mq.size() != 0) && id_ready;
      bit acc = exp_req() && ic_addr_ok;
      if (redirect) begin
         mq.delete();
         m_pc = redirect_pc;
         if (m_pending) begin
            m_pending = 0;
            m_stale = !ic_data_ok;
         end else if (m_stale) begin
            if (ic_data_ok) m_stale = 0;
         end else if (ic_addr_ok) m_stale = 1;
      end else begin
         if (deq) void'(mq.pop_front());
         if (m_stale) begin
            if (ic_data_ok) m_stale = 0;
         end else if (m_pending) begin
            if (ic_data_ok) begin
               e.inst = ic_rdata;
               e.pc = m_req_pc;
               e.pred = pred_of(ic_rdata);
               mq.push_back(e);
               m_pc = e.pred ? target_of(ic_rdata, m_req_pc) : m_req_pc + 64'd4;
               m_pending = 0;
            end
         end else if (acc) begin
            m_pending = 1;
            m_req_pc = m_pc;
         end
      end
   endtask

   // ICache stand-in: accepts only real requests, returns data only when one is in flight.
   task automatic drive_cache(input int addr_pct, input int data_pct, input logic [31:0] inst);
      ic_addr_ok = exp_req() && (int'($urandom_range(99)) < addr_pct);
      ic_data_ok = (m_pending || m_stale) && (int'($urandom_range(99)) < data_pct);
      ic_rdata = inst;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
      end
      tests++;
      if (ic_addr !== RST_PC || ic_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_addr: got addr %h req %b want %h req 0", ic_addr, ic_req, RST_PC);
      end
      rst = 0;
   endtask

   task automatic test_sequential();
      int k = 0;
      id_ready = 1;
      for (int c = 0; c < 16; c++) begin
         drive_cache(100, 100, NOP);
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL seq_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (ic_addr_ok) begin
            tests++;
            if (ic_addr !== RST_PC + 64'(k) * 4) begin
               fails++;
               $display("FAIL seq_addr%0d: got %h want %h", k, ic_addr, RST_PC + 64'(k) * 4);
            end
            k++;
         end
         tick();
      end
   endtask

   task automatic test_predict(input string name, input logic [63:0] at_pc,
                               input logic [31:0] inst, input logic [63:0] exp_next,
                               input bit exp_pred);
      bit hit = 0;
      id_ready = 1;
      redirect = 1;
      redirect_pc = at_pc;
      drive_cache(100, 100, NOP);
      #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
         fails++;
         $display("FAIL %s_redirect: got %h want %h", name, obs_vec(), exp_vec());
      end
      tick();
      redirect = 0;
      for (int c = 0; c < 12 && !hit; c++) begin
         drive_cache(100, 100, (m_pending && m_req_pc == at_pc) ? inst : NOP);
         hit = ic_data_ok && m_pending && m_req_pc == at_pc;
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL %s_cycle%0d: got %h want %h", name, c, obs_vec(), exp_vec());
         end
         tick();
      end
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL %s_timeout: got no fetch of %h want one", name, at_pc);
      end else if (ic_addr !== exp_next || id_pc !== at_pc || id_pred_taken !== exp_pred) begin
         fails++;
         $display("FAIL %s_target: got addr %h pc %h pred %b want %h %h %b", name, ic_addr,
                  id_pc, id_pred_taken, exp_next, at_pc, exp_pred);
      end
   endtask

   task automatic test_full();
      redirect = 1;
      redirect_pc = 64'h8000_0100;
      id_ready = 0;
      drive_cache(100, 100, NOP);
      #1;
      tick();
      redirect = 0;
      for (int c = 0; c < 25; c++) begin
         drive_cache(100, 100, NOP);
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL full_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         tick();
      end
      tests++;
      if (fq_count !== 3'd4 || ic_req !== 1'b0) begin
         fails++;
         $display("FAIL full_stall: got count %0d req %b want 4 0", fq_count, ic_req);
      end
      id_ready = 1;
      drive_cache(100, 100, NOP);
      #1;
      tick();
      #1;
      tests++;
      if (fq_count !== 3'd3 || ic_req !== 1'b1) begin
         fails++;
         $display("FAIL full_resume: got count %0d req %b want 3 1", fq_count, ic_req);
      end
   endtask

   task automatic test_redirect_stale();
      int c = 0;
      id_ready = 1;
      while (!(m_pending && !m_stale) && c < 20) begin
         drive_cache(100, m_stale ? 100 : 0, NOP);
         #1;
         tick();
         c++;
      end
      tests++;
      if (!m_pending) begin
         fails++;
         $display("FAIL stale_setup: got no outstanding fetch want one");
      end
      redirect = 1;
      redirect_pc = 64'h8000_1000;
      drive_cache(0, 0, NOP);
      #1;
      tick();
      redirect = 0;
      for (int k = 0; k < 3; k++) begin
         drive_cache(0, (k == 2) ? 100 : 0, NOP);
         #1;
         tests++;
         if (ic_req !== 1'b0 || obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL stale_drop%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
         tick();
      end
      #1;
      tests++;
      if (fq_count !== 3'd0 || id_valid !== 1'b0 || ic_addr !== 64'h8000_1000 || ic_req !== 1) begin
         fails++;
         $display("FAIL stale_after: got count %0d valid %b addr %h req %b want 0 0 80001000 1",
                  fq_count, id_valid, ic_addr, ic_req);
      end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      redirect = 1;
      redirect_pc = 64'h8000_2000;
      drive_cache(0, 100, NOP);
      #1;
      tick();
      redirect = 0;
      id_ready = 0;
      while (!(mq.size() == 3 && m_pending) && c < 30) begin
         drive_cache(100, 100, NOP);
         #1;
         tick();
         c++;
      end
      tests++;
      if (!(mq.size() == 3 && m_pending) || fq_count !== 3'd3) begin
         fails++;
         $display("FAIL rstmid_setup: got count %0d want 3 with fetch in flight", fq_count);
      end
      #2;
      rst = 1;
      ic_data_ok = 1;
      ic_addr_ok = 0;
      #1;
      m_reset();
      tests++;
      if (ic_req !== 0 || fq_count !== 0 || id_valid !== 0 || ic_addr !== RST_PC) begin
         fails++;
         $display("FAIL rstmid_clear: got req %b count %0d valid %b addr %h want 0 0 0 %h",
                  ic_req, fq_count, id_valid, ic_addr, RST_PC);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      id_ready = 1;
      for (int k = 0; k < 8; k++) begin
         drive_cache(100, 100, NOP);
         #1;
         tests++;
         if (obs_vec() !== exp_vec() || (k == 0 && ic_addr !== RST_PC)) begin
            fails++;
            $display("FAIL rstmid_cycle%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [31:0] r, inst;
      for (int c = 0; c < 2000; c++) begin
         redirect = ($urandom_range(99) < 4);
         redirect_pc = RST_PC + 64'($urandom_range(1023)) * 4;
         id_ready = ($urandom_range(99) < 70);
         r = $urandom;
         case ($urandom_range(4))
            0: inst = NOP;
            1: inst = {r[31:12], 5'd1, 7'b1101111};
            2: inst = {r[31:25], 5'd2, 5'd1, 3'b001, r[11:7], 7'b1100011};
            3: inst = 32'h0000_8067;
            default: inst = r;
         endcase
         drive_cache(60, 50, inst);
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         tick();
      end
      redirect = 0;
   endtask

   initial begin
      rst = 1;
      redirect = 0;
      redirect_pc = '0;
      ic_addr_ok = 0;
      ic_data_ok = 0;
      ic_rdata = '0;
      id_ready = 0;
      m_reset();
      test_reset();
      test_sequential();
      test_predict("jal", 64'h8000_0010, 32'h0200_006F, 64'h8000_0030, 1'b1);
      test_predict("beq_back", 64'h8000_0040, 32'hFE00_0CE3, 64'h8000_0038, 1'b1);
      test_predict("beq_fwd", 64'h8000_0040, 32'h0000_0463, 64'h8000_0044, 1'b0);
      test_full();
      test_redirect_stale();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1);
   end
endmodule
